// File: rtl/score_display_scanner_if.sv
// Score/display bus for score_display_scanner.
//   digits_in : {P1 tens, P1 ones, P2 tens, P2 ones} BCD nibbles
//   load      : 1-cycle strobe capturing digits_in as the pending update
//   digit_en  : per-digit anode enable
//   numout    : nibble for the shared seven-segment decoder
//   an_n      : active-low digit anodes
//   dp_n      : active-low decimal point (score separator)
//   load_ack  : 1-cycle pulse when a pending update reaches the display
// master = score logic side, slave = scanner side.
interface score_display_scanner_if;
  logic [15:0] digits_in;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  numout;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        load_ack;

  modport master (
    output digits_in, load, digit_en,
    input  numout, an_n, dp_n, load_ack
  );

  modport slave (
    input  digits_in, load, digit_en,
    output numout, an_n, dp_n, load_ack
  );
endinterface

// File: rtl/score_display_scanner.sv
// score_display_scanner
//   Time-multiplexes four BCD digits onto one shared seven-segment decoder.
//   Each digit slot is a BLANK guard (all anodes off) followed by a DRIVE
//   phase. Score updates are held pending and committed to the displayed
//   shadow copy only at frame boundaries, so a frame is never torn.
// Ports:
//   Clk : system clock
//   Rst : asynchronous reset, active-high
//   bus : score_display_scanner_if.slave (digits_in/load/digit_en in,
//         numout/an_n/dp_n/load_ack out)
module score_display_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic Clk,
  input  logic Rst,
  score_display_scanner_if.slave bus
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [3:0]    an_reg, an_next;
  logic          dp_reg, dp_next;
  logic [3:0]    num_reg, num_next;
  logic          ack_reg, ack_next;
  logic [15:0]   shadow_reg, shadow_next;
  logic [15:0]   pend_reg, pend_next;
  logic          pv_reg, pv_next;

  logic          boundary;
  logic          suppress;
  logic          digit_on;
  logic [3:0]    cur_nib;

  // Tens digits (3 and 1) blank when zero; ones digits always shown.
  always_comb begin
    cur_nib  = shadow_reg[{idx_reg, 2'b00} +: 4];
    suppress = (LZ_SUPPRESS != 0) &&
               (((idx_reg == 2'd3) && (shadow_reg[15:12] == 4'd0)) ||
                ((idx_reg == 2'd1) && (shadow_reg[7:4]   == 4'd0)));
    digit_on = bus.digit_en[idx_reg] && !suppress;
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + CW'(1);
    idx_next    = idx_reg;
    an_next     = an_reg;
    dp_next     = dp_reg;
    num_next    = num_reg;
    ack_next    = 1'b0;
    shadow_next = shadow_reg;
    pend_next   = pend_reg;
    pv_next     = pv_reg;
    boundary    = 1'b0;

    case (state_reg)
      BLANK: begin
        if (cnt_reg == CW'(BLANK_CYCLES - 1)) begin
          state_next = DRIVE;
          cnt_next   = '0;
          // numout and anode change together; a suppressed or disabled
          // digit still occupies its slot with anodes off.
          num_next   = cur_nib;
          an_next    = digit_on ? ~(4'(4'b0001 << idx_reg)) : 4'hF;
          dp_next    = !(digit_on && (idx_reg == 2'd2));
        end
      end
      DRIVE: begin
        if (cnt_reg == CW'(REFRESH_DIV - 1)) begin
          state_next = BLANK;
          cnt_next   = '0;
          idx_next   = idx_reg + 2'd1;
          an_next    = 4'hF;
          dp_next    = 1'b1;
          boundary   = (idx_reg == 2'd3);
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
      end
    endcase

    // A load landing on the boundary itself wins over any older pending value.
    if (boundary && bus.load) begin
      shadow_next = bus.digits_in;
      pv_next     = 1'b0;
      ack_next    = 1'b1;
    end else if (boundary && pv_reg) begin
      shadow_next = pend_reg;
      pv_next     = 1'b0;
      ack_next    = 1'b1;
    end else if (bus.load) begin
      pend_next = bus.digits_in;
      pv_next   = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg  <= BLANK;
      cnt_reg    <= '0;
      idx_reg    <= 2'd0;
      an_reg     <= 4'hF;
      dp_reg     <= 1'b1;
      num_reg    <= 4'd0;
      ack_reg    <= 1'b0;
      shadow_reg <= 16'd0;
      pend_reg   <= 16'd0;
      pv_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      an_reg     <= an_next;
      dp_reg     <= dp_next;
      num_reg    <= num_next;
      ack_reg    <= ack_next;
      shadow_reg <= shadow_next;
      pend_reg   <= pend_next;
      pv_reg     <= pv_next;
    end
  end

  assign bus.numout   = num_reg;
  assign bus.an_n     = an_reg;
  assign bus.dp_n     = dp_reg;
  assign bus.load_ack = ack_reg;

endmodule
